// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder:
//                FSM state encoding, RISC-V load/store funct3 codes and the
//                captured-request record.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Address is held at full 32-bit width so the record is independent of
    // the array size chosen by the instantiating module.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational byte-lane steering for a 32-bit word memory.
//                Produces the store byte enables and replicated store data,
//                the sign/zero-extended load data, a misalignment flag and
//                an undefined-funct3 flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_al,
    output logic [31:0] o_rdata_ext,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword out of the read word.
    always_comb begin
        w_byte = i_rword[{i_offset, 3'b000} +: 8];
        w_half = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
    end

    // Decode access size: lane enables, store data placement, load extension.
    always_comb begin
        o_be        = 4'b1111;
        o_wdata_al  = i_wdata;
        o_rdata_ext = i_rword;
        o_misalign  = 1'b0;
        o_illegal   = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be        = 4'b0001 << i_offset;
                o_wdata_al  = {4{i_wdata[7:0]}};
                o_rdata_ext = i_funct3[2] ? {24'd0, w_byte}
                                          : {{24{w_byte[7]}}, w_byte};
            end
            F3_H, F3_HU: begin
                // Halfword lanes follow offset[1] only; offset[0] just flags.
                o_be        = i_offset[1] ? 4'b1100 : 4'b0011;
                o_wdata_al  = {2{i_wdata[15:0]}};
                o_rdata_ext = i_funct3[2] ? {16'd0, w_half}
                                          : {{16{w_half[15]}}, w_half};
                o_misalign  = i_offset[0];
            end
            F3_W: begin
                o_misalign  = |i_offset;
            end
            default: begin
                // Undefined codes behave as a word access but are flagged.
                o_illegal   = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder. Accepts one load/store through a
//                valid/ready handshake, waits WAIT_CYC cycles, accesses a
//                byte-enabled word array and returns a one-cycle response
//                pulse with extended load data and an error flag.
//                Optional macro DMEM_MISALIGN_TRAP_EN: misaligned halfword
//                and word accesses are rejected (store suppressed, load data
//                zero, rsp_err set).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int WAIT_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int         c_DEPTH     = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYC);

    dmem_state_e           r_state;
    dmem_state_e           w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    dmem_req_t             r_req;
    logic [DATA_W-1:0]     r_mem [c_DEPTH];

    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_accept;
    logic [DM_ADDRESS-3:0] w_idx;
    logic [DATA_W-1:0]     w_rword;
    logic [3:0]            w_be;
    logic [DATA_W-1:0]     w_wdata_al;
    logic [DATA_W-1:0]     w_rdata_ext;
    logic                  w_misalign;
    logic                  w_illegal;
    logic                  w_trap;
    logic                  w_mem_we;
    logic                  w_unused_bits;

    // Ready only in IDLE and not while the previous response is on the bus.
    assign req_ready = (r_state == IDLE) && !r_rsp_valid;
    assign w_accept  = req_ready && req_valid;

    assign w_idx     = r_req.addr[DM_ADDRESS-1:2];
    assign w_rword   = r_mem[w_idx];

    dmem_lane_align u_lane_align (
        .i_funct3    (r_req.funct3),
        .i_offset    (r_req.addr[1:0]),
        .i_wdata     (r_req.wdata),
        .i_rword     (w_rword),
        .o_be        (w_be),
        .o_wdata_al  (w_wdata_al),
        .o_rdata_ext (w_rdata_ext),
        .o_misalign  (w_misalign),
        .o_illegal   (w_illegal)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_trap        = w_misalign;
    assign w_unused_bits = ^r_req.addr;
`else
    assign w_trap        = 1'b0;
    assign w_unused_bits = ^{r_req.addr, w_misalign};
`endif

    // A reset arriving in the RESP cycle must abort the write.
    assign w_mem_we = (r_state == RESP) && r_req.we && !w_trap && !reset;

    // FSM and wait-counter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: IDLE -> WAIT (WAIT_CYC cycles) -> RESP -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYC > 0) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_WAIT_INIT;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture the request on accept and register the response out of RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= (r_state == RESP);
            if (w_accept) begin
                r_req.we     <= req_we;
                r_req.addr   <= 32'(req_addr);
                r_req.wdata  <= req_wdata;
                r_req.funct3 <= req_funct3;
            end
            if (r_state == RESP) begin
                r_rsp_rdata <= (r_req.we || w_trap) ? '0 : w_rdata_ext;
                r_rsp_err   <= w_illegal || w_trap;
            end
        end
    end

    // Byte-enabled array write; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_mem_we && w_be[i]) begin
                r_mem[w_idx][8*i +: 8] <= w_wdata_al[8*i +: 8];
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Table of single
//                transactions, back-to-back loads with req_valid held high,
//                a reset that aborts a pending store, and the misaligned /
//                undefined-funct3 cases. Responses are matched against a
//                queue of expectations pushed at accept time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;
    localparam int WAIT_CYC   = 2;
    localparam int N_VEC      = 15;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    dmem_responder #(
        .DM_ADDRESS (DM_ADDRESS),
        .DATA_W     (DATA_W),
        .WAIT_CYC   (WAIT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    typedef struct {
        logic                  we;
        logic [DM_ADDRESS-1:0] addr;
        logic [31:0]           wdata;
        logic [2:0]            f3;
        logic [31:0]           rdata;
        logic                  err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[N_VEC];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   chk_ready = 1'b0;
    int   low_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response scoreboard and ready-low run length monitor.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid with no pending request (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                // Response is visible in the (WAIT_CYC+2)-th cycle after accept.
                check("rsp_latency", 32'(cyc - e.acc), 32'(WAIT_CYC + 1));
            end
        end
        if (chk_ready) begin
            if (!req_ready) begin
                low_run++;
            end else if (low_run > 0) begin
                check("ready_low_cycles", 32'(low_run), 32'(WAIT_CYC + 2));
                low_run = 0;
            end
        end
    end

    // Drive one request from a negedge; returns at the negedge after accept.
    task automatic do_req(input logic we, input logic [DM_ADDRESS-1:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input bit hold);
        int n;
        n          = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = f3;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed %b, expected 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        sb.push_back('{exp_rd, exp_err, cyc + 1});
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //        we    addr    wdata         f3      rdata         err
        vecs[0]  = '{1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 9'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b0, 9'h013, 32'h0,        3'b100, 32'h000000DE, 1'b0};
        vecs[4]  = '{1'b0, 9'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{1'b0, 9'h010, 32'h0,        3'b101, 32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b1, 9'h011, 32'h00000055, 3'b000, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0};
        vecs[8]  = '{1'b1, 9'h012, 32'h00001234, 3'b001, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 9'h010, 32'h0,        3'b010, 32'h123455EF, 1'b0};
        vecs[10] = '{1'b0, 9'h010, 32'h0,        3'b000, 32'hFFFFFFEF, 1'b0};
        vecs[11] = '{1'b0, 9'h012, 32'h0,        3'b101, 32'h00001234, 1'b0};
        vecs[12] = '{1'b0, 9'h010, 32'h0,        3'b011, 32'h123455EF, 1'b1};
        vecs[13] = '{1'b1, 9'h030, 32'hCAFEF00D, 3'b111, 32'h00000000, 1'b1};
        vecs[14] = '{1'b0, 9'h030, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("reset");
        mon_en = 1'b1;

        // Single transactions from the table.
        for (int i = 0; i < N_VEC; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
                   vecs[i].rdata, vecs[i].err, 1'b0);
        end
        drain();

        // Back-to-back loads with req_valid held high.
        low_run   = 0;
        chk_ready = 1'b1;
        do_req(1'b0, 9'h010, 32'h0, 3'b010, 32'h123455EF, 1'b0, 1'b1);
        do_req(1'b0, 9'h013, 32'h0, 3'b000, 32'h00000012, 1'b0, 1'b1);
        do_req(1'b0, 9'h010, 32'h0, 3'b101, 32'h000055EF, 1'b0, 1'b1);
        do_req(1'b0, 9'h011, 32'h0, 3'b100, 32'h00000055, 1'b0, 1'b1);
        req_valid = 1'b0;
        drain();
        chk_ready = 1'b0;

        // Reset during WAIT aborts a store and suppresses its response.
        do_req(1'b1, 9'h020, 32'h11223344, 3'b010, 32'h0, 1'b0, 1'b0);
        drain();
        do_req(1'b1, 9'h020, 32'hAAAAAAAA, 3'b010, 32'h0, 1'b0, 1'b0);
        sb.delete();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("midreset");
        repeat (6) @(negedge clk);
        do_req(1'b0, 9'h020, 32'h0, 3'b010, 32'h11223344, 1'b0, 1'b0);
        drain();

        // Misaligned halfword and word accesses.
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(1'b1, 9'h022, 32'h5A5A5A5A, 3'b010, 32'h00000000, 1'b1, 1'b0);
        do_req(1'b0, 9'h020, 32'h0,        3'b010, 32'h11223344, 1'b0, 1'b0);
        do_req(1'b0, 9'h011, 32'h0,        3'b001, 32'h00000000, 1'b1, 1'b0);
`else
        do_req(1'b1, 9'h022, 32'h5A5A5A5A, 3'b010, 32'h00000000, 1'b0, 1'b0);
        do_req(1'b0, 9'h020, 32'h0,        3'b010, 32'h5A5A5A5A, 1'b0, 1'b0);
        do_req(1'b0, 9'h011, 32'h0,        3'b001, 32'h000055EF, 1'b0, 1'b0);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
